lms_adapt_ctrl: RTL

- Adaptation sequencer for the pipelined 2-tap LMS FIR (fir_pipeline_lms family).
- Clears coefficients, waits out the multiplier pipeline, then runs coarse-step TRAIN and switches to fine-step TRACK once windowed error power stays low.
- Re-enters TRAIN on error blow-up; supports freeze/hold and abort.
- Sits beside the LMS datapath: consumes e_out, drives coefficient clear, adapt enable and step-size shift.

---
 rtl/lms_adapt_ctrl_pkg.sv | 22 ++
 rtl/lms_adapt_ctrl_if.sv | 36 +++
 rtl/lms_adapt_ctrl_err_pow.sv | 93 +++++++++
 rtl/lms_adapt_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lms_adapt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lms_pkg
// Shared definitions for the LMS adaptation controller and its datapath.
//   W2            : error word width, shared with fir_pipeline_lms
//   MU_TRAIN_DEF  : default coarse step shift
//   MU_TRACK_DEF  : default fine step shift
//   ST_*          : controller state encodings (also exported on state_o)
// -----------------------------------------------------------------------------
package lms_pkg;

    localparam int W2           = 32;
    localparam int MU_TRAIN_DEF = 1;
    localparam int MU_TRACK_DEF = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_TRAIN = 3'd3;
    localparam logic [2:0] ST_TRACK = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

endpackage

// File: rtl/lms_adapt_ctrl_if.sv
// -----------------------------------------------------------------------------
// lms_adapt_ctrl_if
// Control/status bundle between software/datapath (master) and the adaptation
// controller (slave).
//   master drives : start, stop, freeze, e_in, e_valid, thr_lo, thr_hi
//   slave drives  : coef_clr, adapt_en, mu_shift, converged, err_pow,
//                   pow_valid, state_o
// -----------------------------------------------------------------------------
interface lms_adapt_ctrl_if #(
    parameter int W2 = lms_pkg::W2
);
    logic                 start;
    logic                 stop;
    logic                 freeze;
    logic signed [W2-1:0] e_in;
    logic                 e_valid;
    logic        [W2-1:0] thr_lo;
    logic        [W2-1:0] thr_hi;
    logic                 coef_clr;
    logic                 adapt_en;
    logic        [3:0]    mu_shift;
    logic                 converged;
    logic        [W2-1:0] err_pow;
    logic                 pow_valid;
    logic        [2:0]    state_o;

    modport master (
        output start, stop, freeze, e_in, e_valid, thr_lo, thr_hi,
        input  coef_clr, adapt_en, mu_shift, converged, err_pow, pow_valid, state_o
    );

    modport slave (
        input  start, stop, freeze, e_in, e_valid, thr_lo, thr_hi,
        output coef_clr, adapt_en, mu_shift, converged, err_pow, pow_valid, state_o
    );
endinterface

// File: rtl/lms_adapt_ctrl_err_pow.sv
// -----------------------------------------------------------------------------
// lms_err_pow
// Windowed mean-|e| estimator.
//   clk, rst     : clock, async active-high reset
//   e_in_i       : signed error sample
//   e_valid_i    : sample qualifier
//   acc_en_i     : accumulate this cycle (controller in TRAIN/TRACK, not held)
//   clr_i        : drop partial window (count and accumulator)
//   win_end_o    : this cycle's sample completes the window (combinational)
//   win_mean_o   : mean including this cycle's sample (combinational)
//   err_pow_o    : last completed window mean
//   pow_valid_o  : one-cycle pulse when err_pow_o updates
// -----------------------------------------------------------------------------
module lms_err_pow #(
    parameter int W2       = lms_pkg::W2,
    parameter int WIN_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W2-1:0] e_in_i,
    input  logic                 e_valid_i,
    input  logic                 acc_en_i,
    input  logic                 clr_i,
    output logic                 win_end_o,
    output logic        [W2-1:0] win_mean_o,
    output logic        [W2-1:0] err_pow_o,
    output logic                 pow_valid_o
);
    // Window of 2^WIN_LOG2 magnitudes of at most 2^(W2-1)-1 cannot overflow.
    localparam int AW = W2 + WIN_LOG2;

    logic [W2-1:0]       mag;
    logic [AW-1:0]       sum;
    logic [AW-1:0]       acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [W2-1:0]       err_pow_q, err_pow_d;
    logic                pow_valid_q, pow_valid_d;

    // Two's-complement negation of the most-negative value would wrap back
    // to itself, so it is clamped to the largest positive magnitude.
    always_comb begin
        mag = e_in_i;
        if (e_in_i[W2-1]) begin
            if (e_in_i == {1'b1, {(W2-1){1'b0}}})
                mag = {1'b0, {(W2-1){1'b1}}};
            else
                mag = -e_in_i;
        end
    end

    assign sum        = acc_q + AW'(mag);
    assign win_end_o  = acc_en_i & e_valid_i & (cnt_q == '1);
    assign win_mean_o = W2'(sum >> WIN_LOG2);

    // Clearing beats accumulation; the window counter wraps to zero on its own
    // at window end.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_pow_d   = err_pow_q;
        pow_valid_d = win_end_o;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (acc_en_i && e_valid_i) begin
            cnt_d = cnt_q + 1'b1;
            if (win_end_o) begin
                acc_d     = '0;
                err_pow_d = win_mean_o;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            err_pow_q   <= '0;
            pow_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_pow_q   <= err_pow_d;
            pow_valid_q <= pow_valid_d;
        end
    end

    assign err_pow_o   = err_pow_q;
    assign pow_valid_o = pow_valid_q;

endmodule

// File: rtl/lms_adapt_ctrl.sv
// -----------------------------------------------------------------------------
// lms_adapt_ctrl
// Adaptation sequencer for the pipelined 2-tap LMS FIR.
//   clk, rst : clock, async active-high reset
//   bus      : lms_adapt_ctrl_if.slave
//              in : start, stop, freeze, e_in, e_valid, thr_lo, thr_hi
//              out: coef_clr, adapt_en, mu_shift, converged, err_pow,
//                   pow_valid, state_o (all registered)
// Flow: IDLE -> CLEAR -> FLUSH -> TRAIN <-> TRACK, HOLD while frozen.
// -----------------------------------------------------------------------------
module lms_adapt_ctrl
    import lms_pkg::*;
#(
    parameter int W2       = lms_pkg::W2,
    parameter int WIN_LOG2 = 6,
    parameter int PIPE_LAT = 4,
    parameter int LOCK_CNT = 4,
    parameter int MU_TRAIN = MU_TRAIN_DEF,
    parameter int MU_TRACK = MU_TRACK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    lms_adapt_ctrl_if.slave bus
);
    logic [2:0]    state_q, state_d;
    logic [2:0]    ret_q, ret_d;
    logic [3:0]    lock_q, lock_d;
    logic [7:0]    flush_q, flush_d;
    logic          coef_clr_q, coef_clr_d;
    logic          adapt_en_q, adapt_en_d;
    logic [3:0]    mu_shift_q, mu_shift_d;
    logic          converged_q, converged_d;

    logic          acc_en;
    logic          err_clr;
    logic          win_end;
    logic [W2-1:0] win_mean;

    // freeze and stop both suppress accumulation so a window cannot close
    // on the cycle the controller leaves TRAIN/TRACK.
    assign acc_en  = !bus.stop && !bus.freeze &&
                     (state_q == ST_TRAIN || state_q == ST_TRACK);
    assign err_clr = bus.stop || (state_q == ST_CLEAR);

    lms_err_pow #(
        .W2       (W2),
        .WIN_LOG2 (WIN_LOG2)
    ) u_err_pow (
        .clk         (clk),
        .rst         (rst),
        .e_in_i      (bus.e_in),
        .e_valid_i   (bus.e_valid),
        .acc_en_i    (acc_en),
        .clr_i       (err_clr),
        .win_end_o   (win_end),
        .win_mean_o  (win_mean),
        .err_pow_o   (bus.err_pow),
        .pow_valid_o (bus.pow_valid)
    );

    // Next-state logic; stop overrides everything, freeze overrides the
    // window decision inside TRAIN/TRACK.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        lock_d  = lock_q;
        flush_d = flush_q;
        if (bus.stop) begin
            state_d = ST_IDLE;
            lock_d  = '0;
            flush_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    state_d = ST_FLUSH;
                    lock_d  = '0;
                    flush_d = '0;
                end
                ST_FLUSH: begin
                    if (bus.e_valid) begin
                        if (flush_q == 8'(PIPE_LAT - 1)) state_d = ST_TRAIN;
                        else                             flush_d = flush_q + 8'd1;
                    end
                end
                ST_TRAIN: begin
                    if (bus.freeze) begin
                        state_d = ST_HOLD;
                        ret_d   = ST_TRAIN;
                    end else if (win_end) begin
                        if (win_mean < bus.thr_lo) begin
                            if (lock_q + 4'd1 == 4'(LOCK_CNT)) begin
                                state_d = ST_TRACK;
                                lock_d  = '0;
                            end else begin
                                lock_d = lock_q + 4'd1;
                            end
                        end else begin
                            lock_d = '0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (bus.freeze) begin
                        state_d = ST_HOLD;
                        ret_d   = ST_TRACK;
                    end else if (win_end && (win_mean > bus.thr_hi)) begin
                        state_d = ST_TRAIN;
                        lock_d  = '0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.freeze) state_d = ret_q;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with state_o.
    // HOLD keeps the step size and convergence flag of the state it froze.
    always_comb begin
        coef_clr_d  = (state_d == ST_CLEAR);
        adapt_en_d  = (state_d == ST_TRAIN) || (state_d == ST_TRACK);
        converged_d = (state_d == ST_TRACK) ||
                      ((state_d == ST_HOLD) && (ret_d == ST_TRACK));
        case (state_d)
            ST_TRACK: mu_shift_d = 4'(MU_TRACK);
            ST_HOLD:  mu_shift_d = mu_shift_q;
            default:  mu_shift_d = 4'(MU_TRAIN);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_TRAIN;
            lock_q      <= '0;
            flush_q     <= '0;
            coef_clr_q  <= 1'b0;
            adapt_en_q  <= 1'b0;
            mu_shift_q  <= 4'(MU_TRAIN);
            converged_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            lock_q      <= lock_d;
            flush_q     <= flush_d;
            coef_clr_q  <= coef_clr_d;
            adapt_en_q  <= adapt_en_d;
            mu_shift_q  <= mu_shift_d;
            converged_q <= converged_d;
        end
    end

    assign bus.state_o   = state_q;
    assign bus.coef_clr  = coef_clr_q;
    assign bus.adapt_en  = adapt_en_q;
    assign bus.mu_shift  = mu_shift_q;
    assign bus.converged = converged_q;

endmodule
